// File: rtl/z80_io_target.sv
// rtl/z80_io_target.sv - Z80 I/O port target with wait-state control and a backend request handshake.
// Optional interrupt support (pending flag, vectored acknowledge) is enabled by defining Z80_IO_TARGET_IRQ_EN.
module z80_io_target #(
    parameter logic [7:0] PORT_BASE  = 8'h10,
    parameter logic [7:0] PORT_MASK  = 8'hF0,
    parameter int         WAIT_MIN   = 1,
    parameter logic [7:0] IRQ_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_do,
    input  logic        m1_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic [7:0]  cpu_di,
    output logic        di_en,
    output logic        wait_n,
    output logic        int_n,
    input  logic        irq_in,
    output logic        be_req,
    output logic        be_we,
    output logic [7:0]  be_addr,
    output logic [7:0]  be_wdata,
    input  logic [7:0]  be_rdata,
    input  logic        be_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        acked, acked_nx;
    logic        aborted, aborted_nx;
    logic        latch, capture;
    logic [7:0]  rdata_q;
    logic        hit;
    logic        ack_cyc;

    assign hit = ~iorq_n & m1_n & (rd_n ^ wr_n) &
                 ((A[7:0] & PORT_MASK) == (PORT_BASE & PORT_MASK));

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        acked_nx   = acked;
        aborted_nx = aborted;
        latch      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    latch      = 1'b1;
                    cnt_nx     = 4'(WAIT_MIN);
                    acked_nx   = 1'b0;
                    aborted_nx = 1'b0;
                    state_nx   = REQ;
                end
            end
            REQ: begin
                if (cnt != 4'd0)
                    cnt_nx = cnt - 4'd1;
                if (be_ack)
                    acked_nx = 1'b1;
                if (iorq_n)
                    aborted_nx = 1'b1;
                // The backend must always be allowed to finish; an abandoned cycle just skips DONE.
                if ((be_ack || acked) && cnt == 4'd0) begin
                    if (aborted || iorq_n) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = DONE;
                        capture  = ~be_we;
                    end
                end
            end
            DONE: begin
                if (iorq_n)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            acked    <= 1'b0;
            aborted  <= 1'b0;
            be_we    <= 1'b0;
            be_addr  <= 8'h00;
            be_wdata <= 8'h00;
            rdata_q  <= 8'h00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            acked   <= acked_nx;
            aborted <= aborted_nx;
            if (latch) begin
                be_we    <= ~wr_n;
                be_addr  <= A[7:0] & ~PORT_MASK;
                be_wdata <= cpu_do;
            end
            if (capture)
                rdata_q <= be_rdata;
        end
    end

    assign be_req = (state == REQ) && !acked;
    assign wait_n = ~(((state == IDLE) && hit) || (state == REQ));

`ifdef Z80_IO_TARGET_IRQ_EN
    logic irq_q, ack_q, pending, again;
    logic edge_det, ack_end;

    assign ack_cyc  = ~m1_n & ~iorq_n;
    assign edge_det = irq_in & ~irq_q;
    assign ack_end  = ack_q & iorq_n;

    // An edge seen during an acknowledge is a fresh request and survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
            pending <= 1'b0;
            again   <= 1'b0;
        end else begin
            irq_q <= irq_in;
            ack_q <= ack_cyc;
            if (ack_end) begin
                pending <= again | edge_det;
                again   <= 1'b0;
            end else begin
                if (edge_det)
                    pending <= 1'b1;
                if (edge_det && ack_cyc)
                    again <= 1'b1;
            end
        end
    end

    assign int_n = ~pending;

    logic unused_ok;
    assign unused_ok = &{1'b0, A[15:8]};
`else
    assign ack_cyc = 1'b0;
    assign int_n   = 1'b1;

    logic unused_ok;
    assign unused_ok = &{1'b0, A[15:8], irq_in};
`endif

    assign di_en  = ((state == DONE) && !be_we && !rd_n) || ack_cyc;
    assign cpu_di = ack_cyc ? IRQ_VECTOR : rdata_q;

endmodule

// File: tb/tb_z80_io_target.sv
// tb/tb_z80_io_target.sv - Directed self-checking bench for z80_io_target.
module tb_z80_io_target;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  cpu_do;
    logic        m1_n, iorq_n, rd_n, wr_n;
    logic        irq_in;
    logic [7:0]  be_rdata;
    logic        be_ack;

    logic [7:0]  cpu_di, be_addr, be_wdata;
    logic        di_en, wait_n, int_n, be_req, be_we;

    logic [7:0]  cpu_di4, be_addr4, be_wdata4;
    logic        di_en4, wait_n4, int_n4, be_req4, be_we4;
    logic        be_ack4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    z80_io_target dut (
        .clk(clk), .reset(reset), .A(A), .cpu_do(cpu_do),
        .m1_n(m1_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .cpu_di(cpu_di), .di_en(di_en), .wait_n(wait_n), .int_n(int_n),
        .irq_in(irq_in), .be_req(be_req), .be_we(be_we), .be_addr(be_addr),
        .be_wdata(be_wdata), .be_rdata(be_rdata), .be_ack(be_ack)
    );

    // Second target at port 0x4x with four wait states and an always-ready backend.
    assign be_ack4 = be_req4;

    z80_io_target #(.PORT_BASE(8'h40), .WAIT_MIN(4)) dut4 (
        .clk(clk), .reset(reset), .A(A), .cpu_do(cpu_do),
        .m1_n(m1_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .cpu_di(cpu_di4), .di_en(di_en4), .wait_n(wait_n4), .int_n(int_n4),
        .irq_in(irq_in), .be_req(be_req4), .be_we(be_we4), .be_addr(be_addr4),
        .be_wdata(be_wdata4), .be_rdata(be_rdata), .be_ack(be_ack4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_in(input string t);
        tick; A = 16'h0013; iorq_n = 1'b0; rd_n = 1'b0; #1;
        chk({t, ".wait_hit"}, 16'(wait_n), 16'h0);
        chk({t, ".req_idle"}, 16'(be_req), 16'h0);
        tick;
        chk({t, ".req_on"}, 16'(be_req), 16'h1);
        chk({t, ".addr"}, 16'(be_addr), 16'h03);
        chk({t, ".we"}, 16'(be_we), 16'h0);
        chk({t, ".wait_req"}, 16'(wait_n), 16'h0);
        tick; be_ack = 1'b1; be_rdata = 8'hA5; #1;
        chk({t, ".req_hold"}, 16'(be_req), 16'h1);
        chk({t, ".wait_hold"}, 16'(wait_n), 16'h0);
        tick; be_ack = 1'b0; #1;
        chk({t, ".wait_done"}, 16'(wait_n), 16'h1);
        chk({t, ".di_en_done"}, 16'(di_en), 16'h1);
        chk({t, ".cpu_di"}, 16'(cpu_di), 16'hA5);
        chk({t, ".req_off"}, 16'(be_req), 16'h0);
        iorq_n = 1'b1; rd_n = 1'b1; #1;
        chk({t, ".di_en_rel"}, 16'(di_en), 16'h0);
        tick;
        chk({t, ".wait_idle"}, 16'(wait_n), 16'h1);
    endtask

    initial begin
        int n;
        reset = 1'b1; A = 16'h0000; cpu_do = 8'h00;
        m1_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        irq_in = 1'b0; be_rdata = 8'h00; be_ack = 1'b0;
        tick; tick;
        reset = 1'b0; #1;

        chk("rst.be_req", 16'(be_req), 16'h0);
        chk("rst.wait_n", 16'(wait_n), 16'h1);
        chk("rst.di_en", 16'(di_en), 16'h0);
        chk("rst.cpu_di", 16'(cpu_di), 16'h00);
        chk("rst.int_n", 16'(int_n), 16'h1);
        chk("rst.be_addr", 16'(be_addr), 16'h00);
        chk("rst.be_we", 16'(be_we), 16'h0);
        chk("rst.be_wdata", 16'(be_wdata), 16'h00);

        do_in("in13");

        // OUT 0x3C to port 0x1F, ack one cycle after be_req rises.
        tick; A = 16'h001F; cpu_do = 8'h3C; iorq_n = 1'b0; wr_n = 1'b0; #1;
        chk("out.wait_hit", 16'(wait_n), 16'h0);
        tick;
        chk("out.req_on", 16'(be_req), 16'h1);
        chk("out.we", 16'(be_we), 16'h1);
        chk("out.addr", 16'(be_addr), 16'h0F);
        chk("out.wdata", 16'(be_wdata), 16'h3C);
        be_ack = 1'b1;
        tick; be_ack = 1'b0; #1;
        chk("out.req_off_after_ack", 16'(be_req), 16'h0);
        chk("out.wait_count", 16'(wait_n), 16'h0);
        tick;
        chk("out.wait_done", 16'(wait_n), 16'h1);
        chk("out.di_en", 16'(di_en), 16'h0);
        iorq_n = 1'b1; wr_n = 1'b1;
        tick;

        // Non-matching port, then a memory read at 0x0010.
        A = 16'h0020; iorq_n = 1'b0; rd_n = 1'b0; #1;
        chk("miss.wait_n", 16'(wait_n), 16'h1);
        tick;
        chk("miss.be_req", 16'(be_req), 16'h0);
        chk("miss.di_en", 16'(di_en), 16'h0);
        iorq_n = 1'b1; A = 16'h0010; #1;
        chk("mem.wait_n", 16'(wait_n), 16'h1);
        tick;
        chk("mem.be_req", 16'(be_req), 16'h0);
        chk("mem.di_en", 16'(di_en), 16'h0);
        rd_n = 1'b1;
        tick;

        // Four minimum wait states with an immediate backend ack.
        A = 16'h0040; iorq_n = 1'b0; rd_n = 1'b0; #1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (wait_n4 !== 1'b0) break;
            n++;
            chk("wm4.dut1_wait_n", 16'(wait_n), 16'h1);
            tick;
        end
        chk("wm4.low_ge5", 16'(n >= 5), 16'h1);
        chk("wm4.low_bounded", 16'(n < 20), 16'h1);
        chk("wm4.dut1_be_req", 16'(be_req), 16'h0);
        iorq_n = 1'b1; rd_n = 1'b1;
        tick;

        // Reset in the middle of a request.
        A = 16'h0013; iorq_n = 1'b0; rd_n = 1'b0;
        tick;
        chk("rstreq.req_on", 16'(be_req), 16'h1);
        reset = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
        tick;
        reset = 1'b0; #1;
        chk("rstreq.be_req", 16'(be_req), 16'h0);
        chk("rstreq.wait_n", 16'(wait_n), 16'h1);
        chk("rstreq.be_addr", 16'(be_addr), 16'h00);
        do_in("in_after_rst");

`ifdef Z80_IO_TARGET_IRQ_EN
        irq_in = 1'b1;
        tick;
        chk("irq.int_low", 16'(int_n), 16'h0);
        m1_n = 1'b0; iorq_n = 1'b0; #1;
        chk("irq.ack_di_en", 16'(di_en), 16'h1);
        chk("irq.ack_vec", 16'(cpu_di), 16'hFF);
        chk("irq.ack_wait", 16'(wait_n), 16'h1);
        tick;
        m1_n = 1'b1; iorq_n = 1'b1;
        tick;
        chk("irq.cleared", 16'(int_n), 16'h1);
        irq_in = 1'b0;
        tick;
        irq_in = 1'b1;
        tick;
        chk("irq2.int_low", 16'(int_n), 16'h0);
        m1_n = 1'b0; iorq_n = 1'b0; irq_in = 1'b0;
        tick;
        irq_in = 1'b1;
        tick;
        m1_n = 1'b1; iorq_n = 1'b1;
        tick;
        chk("irq2.stays_pending", 16'(int_n), 16'h0);
        m1_n = 1'b0; iorq_n = 1'b0;
        tick;
        m1_n = 1'b1; iorq_n = 1'b1;
        tick;
        chk("irq3.cleared", 16'(int_n), 16'h1);
`else
        irq_in = 1'b1;
        tick;
        chk("noirq.int_n", 16'(int_n), 16'h1);
        m1_n = 1'b0; iorq_n = 1'b0; #1;
        chk("noirq.ack_di_en", 16'(di_en), 16'h0);
        chk("noirq.ack_wait", 16'(wait_n), 16'h1);
        tick;
        m1_n = 1'b1; iorq_n = 1'b1;
        tick;
        chk("noirq.int_n_after", 16'(int_n), 16'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/z80_io_target.md
Z80_IO_TARGET -- requirements
Module: z80_io_target

Interface
REQ-001 SHALL have parameter PORT_BASE, default 8'h10; the I/O port base address compared against A[7:0].
REQ-002 SHALL have parameter PORT_MASK, default 8'hF0; A[7:0] bits set in the mask participate in the decode.
REQ-003 SHALL have parameter WAIT_MIN, default 1; minimum wait cycles per access, range 0..15.
REQ-004 SHALL have parameter IRQ_VECTOR, default 8'hFF; byte supplied on interrupt acknowledge.
REQ-005 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- A  in  16  CPU address.
- cpu_do  in  8  CPU write data.
- m1_n, iorq_n, rd_n, wr_n  in  1 each  CPU strobes, active low, registered on clk by the CPU.
- cpu_di  out  8  read or vector data to the CPU.
- di_en  out  1  cpu_di valid; bus mux select.
- wait_n  out  1  CPU wait, active low.
- int_n  out  1  interrupt request, active low.
- irq_in  in  1  interrupt source; rising edge requests.
- be_req  out  1  backend request.
- be_we  out  1  backend write, 1 = write.
- be_addr  out  8  A[7:0] & ~PORT_MASK.
- be_wdata  out  8  write data.
- be_rdata  in  8  backend read data.
- be_ack  in  1  backend completion, one-cycle pulse.
REQ-006 Clocking and reset are fixed: one clock, clk; reset is synchronous and active-high.

Function
REQ-007 hit = ~iorq_n & m1_n & (rd_n ^ wr_n) & ((A[7:0] & PORT_MASK) == (PORT_BASE & PORT_MASK)).
REQ-008 FSM states SHALL be IDLE, REQ, DONE.
REQ-009 In IDLE, hit SHALL latch be_we = ~wr_n, be_addr, and be_wdata = cpu_do, load the wait counter with WAIT_MIN, and move to REQ on the next edge.
REQ-010 In REQ, be_req SHALL be 1 and SHALL stay 1 until be_ack is sampled high; the counter SHALL decrement to 0 and saturate there.
REQ-011 In REQ, when be_ack = 1 and counter = 0, the FSM SHALL move to DONE; a read SHALL capture be_rdata into cpu_di.
REQ-012 In REQ, when be_ack arrives with counter > 0, the ack SHALL be recorded and DONE entered when the counter reaches 0.
REQ-013 wait_n SHALL be combinational: 0 when (IDLE & hit) or REQ; 1 otherwise.
REQ-014 In DONE, di_en SHALL be 1 for reads while rd_n = 0; the FSM SHALL return to IDLE when iorq_n = 1.
REQ-015 In REQ, if iorq_n returns high before ack: still wait for be_ack, then go to IDLE directly and discard read data.
REQ-016 Memory cycles (mreq_n = 0) and non-matching ports SHALL produce no response: wait_n = 1, di_en = 0.
REQ-017 A rising edge of irq_in (registered compare with the previous sample) SHALL set pending; int_n = ~pending.
REQ-018 Interrupt acknowledge (~m1_n & ~iorq_n): cpu_di = IRQ_VECTOR, di_en = 1; pending clears at acknowledge end (iorq_n rising).
REQ-019 An irq_in rising edge in the same cycle as pending clears SHALL leave pending set.
REQ-020 A new request SHALL NOT start until the FSM has returned to IDLE.

Reset
REQ-021 Reset SHALL force: FSM IDLE, be_req 0, be_we 0, be_addr 0, be_wdata 0, cpu_di 0, di_en 0, pending 0, irq_in history 0, counter 0.
REQ-022 Reset mid-access SHALL drop be_req the next cycle and force wait_n to 1 unless a new hit is present.

Configuration
REQ-023 Macro Z80_IO_TARGET_IRQ_EN defined: REQ-017..019 implemented.
REQ-024 Macro Z80_IO_TARGET_IRQ_EN undefined: int_n tied 1; no pending register; acknowledge cycles ignored (di_en 0); irq_in unused.

Verification
REQ-025 IN from port 8'h13, WAIT_MIN 1, be_ack 2 cycles after be_req -> be_addr 8'h03; wait_n low until ack; cpu_di = be_rdata (8'hA5); di_en high in DONE.
REQ-026 OUT of 8'h3C to port 8'h1F -> be_we 1, be_addr 8'h0F, be_wdata 8'h3C; be_req high exactly until ack.
REQ-027 WAIT_MIN 4 with immediate ack -> wait_n low for at least 5 cycles.
REQ-028 IN from port 8'h20 and a memory read at 16'h0010 -> no be_req; wait_n 1; di_en 0.
REQ-029 With the IRQ macro: irq_in rises -> int_n 0; acknowledge -> cpu_di 8'hFF, di_en 1; int_n 1 after iorq_n rises; a second edge during acknowledge -> int_n stays 0.
REQ-030 reset asserted in REQ -> next cycle be_req 0, state IDLE; subsequent IN completes normally.
